// File: rtl/qu_common.sv
// Shared parameters and types for the rename busy table.
// Holds the default physical register file depth, checkpoint count,
// the address/checkpoint-id typedefs and a checkpoint-id range helper.
package qu_common;

    localparam int PHY_RF_DEPTH = 64;
    localparam int NUM_CKPT     = 4;
    localparam int AW           = $clog2(PHY_RF_DEPTH);
    localparam int CW           = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;

    typedef logic [AW-1:0] phy_addr_t;
    typedef logic [CW-1:0] ckpt_id_t;

    // A checkpoint id is usable only if it names an existing slot; this
    // matters when the slot count is not a power of two.
    function automatic logic ckpt_id_ok(input int unsigned id, input int unsigned num_slots);
        return (id < num_slots);
    endfunction

endpackage

// File: rtl/busy_popcount.sv
// Combinational population count of the busy vector; its result is
// registered by the parent as the busy counter.
module busy_popcount #(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_bits,
    output logic [CNT_W-1:0] o_count
);

    // Plain adder chain; synthesis rebalances it into a tree.
    always_comb begin
        o_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_count = o_count + CNT_W'(i_bits[i]);
        end
    end

endmodule

// File: rtl/multiport_busy_table.sv
// Multiport physical-register busy table with branch checkpoints.
// Reads are combinational; sets/clears/saves/restores update on the
// rising clock edge. Physical register 0 is hard-wired not busy.
// Optional feature: define QU_BUSY_TABLE_BYPASS_EN to let a same-cycle
// clear (writeback wakeup) mask rd_busy combinationally.
module multiport_busy_table #(
    parameter int PHY_RF_DEPTH = qu_common::PHY_RF_DEPTH,
    parameter int NUM_RD       = 4,
    parameter int NUM_SET      = 2,
    parameter int NUM_CLR      = 2,
    parameter int NUM_CKPT     = qu_common::NUM_CKPT,
    parameter int AW           = $clog2(PHY_RF_DEPTH),
    parameter int CW           = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_RD-1:0][AW-1:0]      rd_addr,
    output logic [NUM_RD-1:0]              rd_busy,
    input  logic [NUM_SET-1:0]             set_en,
    input  logic [NUM_SET-1:0][AW-1:0]     set_addr,
    input  logic [NUM_CLR-1:0]             clr_en,
    input  logic [NUM_CLR-1:0][AW-1:0]     clr_addr,
    input  logic                           ckpt_save_en,
    input  logic [CW-1:0]                  ckpt_save_id,
    input  logic                           ckpt_restore_en,
    input  logic [CW-1:0]                  ckpt_restore_id,
    output logic [AW:0]                    busy_count
);

    import qu_common::*;

    logic [PHY_RF_DEPTH-1:0] r_table;
    // Kept as flops: every slot is cleared in parallel on writeback.
    logic [PHY_RF_DEPTH-1:0] r_ckpt [NUM_CKPT];
    logic [AW:0]             r_busy_count;

    logic [PHY_RF_DEPTH-1:0] w_set_mask;
    logic [PHY_RF_DEPTH-1:0] w_clr_mask;
    logic [PHY_RF_DEPTH-1:0] w_base;
    logic [PHY_RF_DEPTH-1:0] w_table_next;
    logic                    w_restore_ok;
    logic                    w_save_ok;
    logic [AW:0]             w_pop;

    // Collapse the set and clear ports into one-hot-OR masks; address 0 never participates.
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        for (int p = 0; p < NUM_SET; p++) begin
            if (set_en[p] && (set_addr[p] != '0)) begin
                w_set_mask[set_addr[p]] = 1'b1;
            end
        end
        for (int p = 0; p < NUM_CLR; p++) begin
            if (clr_en[p] && (clr_addr[p] != '0)) begin
                w_clr_mask[clr_addr[p]] = 1'b1;
            end
        end
    end

    // Qualify checkpoint commands; a restore wins over any save in the same cycle.
    always_comb begin
        w_restore_ok = ckpt_restore_en && ckpt_id_ok(32'(ckpt_restore_id), NUM_CKPT);
        w_save_ok    = ckpt_save_en && ckpt_id_ok(32'(ckpt_save_id), NUM_CKPT) && !w_restore_ok;
    end

    // Next table: restore (or current) -> clears -> sets, sets dropped on restore.
    always_comb begin
        w_base       = w_restore_ok ? r_ckpt[ckpt_restore_id] : r_table;
        w_table_next = (w_base & ~w_clr_mask) | (w_restore_ok ? '0 : w_set_mask);
        w_table_next[0] = 1'b0;
    end

    busy_popcount #(
        .WIDTH (PHY_RF_DEPTH),
        .CNT_W (AW + 1)
    ) u_popcount (
        .i_bits  (w_table_next),
        .o_count (w_pop)
    );

    // Live table and its registered population count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_table      <= '0;
            r_busy_count <= '0;
        end else begin
            r_table      <= w_table_next;
            r_busy_count <= w_pop;
        end
    end

    // Checkpoint slots: save captures the next table, otherwise writebacks scrub every slot.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CKPT; k++) begin
            if (rst) begin
                r_ckpt[k] <= '0;
            end else if (w_save_ok && (ckpt_save_id == CW'(k))) begin
                r_ckpt[k] <= w_table_next;
            end else begin
                r_ckpt[k] <= r_ckpt[k] & ~w_clr_mask;
            end
        end
    end

    assign busy_count = r_busy_count;

    // Read ports: table lookup, optionally masked by a same-cycle writeback.
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
`ifdef QU_BUSY_TABLE_BYPASS_EN
        assign rd_busy[gi] = (rd_addr[gi] != '0) && r_table[rd_addr[gi]]
                             && !w_clr_mask[rd_addr[gi]];
`else
        assign rd_busy[gi] = (rd_addr[gi] != '0) && r_table[rd_addr[gi]];
`endif
    end

endmodule

// File: tb/tb_multiport_busy_table.sv
// Directed, table-driven bench for multiport_busy_table (default parameters).
module tb_multiport_busy_table;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0][5:0]   rd_addr;
    logic [3:0]        rd_busy;
    logic [1:0]        set_en;
    logic [1:0][5:0]   set_addr;
    logic [1:0]        clr_en;
    logic [1:0][5:0]   clr_addr;
    logic              ckpt_save_en;
    logic [1:0]        ckpt_save_id;
    logic              ckpt_restore_en;
    logic [1:0]        ckpt_restore_id;
    logic [6:0]        busy_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multiport_busy_table dut (
        .clk             (clk),
        .rst             (rst),
        .rd_addr         (rd_addr),
        .rd_busy         (rd_busy),
        .set_en          (set_en),
        .set_addr        (set_addr),
        .clr_en          (clr_en),
        .clr_addr        (clr_addr),
        .ckpt_save_en    (ckpt_save_en),
        .ckpt_save_id    (ckpt_save_id),
        .ckpt_restore_en (ckpt_restore_en),
        .ckpt_restore_id (ckpt_restore_id),
        .busy_count      (busy_count)
    );

    typedef struct {
        logic            rst;
        logic [1:0]      se;
        logic [1:0][5:0] sa;
        logic [1:0]      ce;
        logic [1:0][5:0] ca;
        logic            sv;
        logic [1:0]      sv_id;
        logic            rs;
        logic [1:0]      rs_id;
        logic [3:0][5:0] ra;
        logic [3:0]      exp_busy;   // bit i = expected rd_busy for ra[i]
        logic [6:0]      exp_cnt;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic r, input logic [1:0] se, input int sa0, input int sa1,
                                input logic [1:0] ce, input int ca0, input int ca1,
                                input logic sv, input int svid, input logic rs, input int rsid,
                                input int r0, input int r1, input int r2, input int r3,
                                input logic [3:0] eb, input int cnt);
        vec_t v;
        v.rst = r;   v.se = se; v.ce = ce;
        v.sa[0] = 6'(sa0); v.sa[1] = 6'(sa1);
        v.ca[0] = 6'(ca0); v.ca[1] = 6'(ca1);
        v.sv = sv; v.sv_id = 2'(svid); v.rs = rs; v.rs_id = 2'(rsid);
        v.ra[0] = 6'(r0); v.ra[1] = 6'(r1); v.ra[2] = 6'(r2); v.ra[3] = 6'(r3);
        v.exp_busy = eb; v.exp_cnt = 7'(cnt);
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0d want=%0d", name, idx, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; set_en = '0; clr_en = '0;
        ckpt_save_en = 1'b0; ckpt_restore_en = 1'b0;
    endtask

    // One edge, then drop all command inputs so reads see only the table.
    task automatic tick();
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
    endtask

    initial begin
        // rst, set_en, sa0, sa1, clr_en, ca0, ca1, save, sid, restore, rid, reads x4, exp bits (MSB=read3), count
        vecs[0]  = mk(1, 2'b11, 9, 9, 2'b00, 0, 0, 1, 0, 1, 0,  1, 2, 3, 0, 4'b0000, 0);
        vecs[1]  = mk(0, 2'b11, 1, 2, 2'b00, 0, 0, 0, 0, 0, 0,  1, 2, 3, 0, 4'b0011, 2);
        vecs[2]  = mk(0, 2'b01, 5, 0, 2'b10, 0, 5, 0, 0, 0, 0,  5, 1, 2, 0, 4'b0111, 3);
        vecs[3]  = mk(0, 2'b11, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0,  0, 5, 1, 2, 4'b1110, 3);
        vecs[4]  = mk(0, 2'b11, 6, 6, 2'b11, 1, 1, 0, 0, 0, 0,  6, 1, 2, 5, 4'b1101, 3);
        vecs[5]  = mk(0, 2'b01, 3, 0, 2'b00, 0, 0, 0, 0, 0, 0,  3, 2, 5, 6, 4'b1111, 4);
        vecs[6]  = mk(0, 2'b01, 4, 0, 2'b00, 0, 0, 1, 1, 0, 0,  4, 3, 9, 0, 4'b0011, 5);
        vecs[7]  = mk(0, 2'b01, 9, 0, 2'b00, 0, 0, 0, 0, 0, 0,  9, 4, 3, 0, 4'b0111, 6);
        vecs[8]  = mk(0, 2'b00, 0, 0, 2'b01, 3, 0, 0, 0, 0, 0,  3, 9, 4, 0, 4'b0110, 5);
        vecs[9]  = mk(0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1,  3, 4, 9, 2, 4'b1010, 4);
        vecs[10] = mk(0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 2, 0, 0,  2, 4, 5, 6, 4'b1111, 4);
        vecs[11] = mk(0, 2'b01, 7, 0, 2'b00, 0, 0, 0, 0, 0, 0,  7, 0, 0, 0, 4'b0001, 5);
        vecs[12] = mk(0, 2'b01, 10, 0, 2'b01, 4, 0, 1, 2, 1, 2, 10, 4, 7, 2, 4'b1000, 3);
        vecs[13] = mk(0, 2'b01, 11, 0, 2'b00, 0, 0, 0, 0, 0, 0, 11, 2, 5, 6, 4'b1111, 4);
        vecs[14] = mk(0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 1, 2, 11, 4, 2, 10, 4'b0100, 3);
        vecs[15] = mk(0, 2'b01, 12, 0, 2'b00, 0, 0, 0, 0, 0, 0, 12, 0, 0, 0, 4'b0001, 4);
        vecs[16] = mk(0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 3, 1, 1, 12, 2, 5, 6, 4'b1110, 3);
        vecs[17] = mk(0, 2'b01, 13, 0, 2'b00, 0, 0, 0, 0, 0, 0, 13, 0, 0, 0, 4'b0001, 4);
        vecs[18] = mk(0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 1, 3,  2, 5, 6, 13, 4'b0000, 0);

        idle_inputs();
        rd_addr = '0; set_addr = '0; clr_addr = '0;
        ckpt_save_id = '0; ckpt_restore_id = '0;

        // Table-driven part.
        for (int v = 0; v < NVEC; v++) begin
            rst = vecs[v].rst;
            set_en = vecs[v].se;  set_addr = vecs[v].sa;
            clr_en = vecs[v].ce;  clr_addr = vecs[v].ca;
            ckpt_save_en = vecs[v].sv;    ckpt_save_id = vecs[v].sv_id;
            ckpt_restore_en = vecs[v].rs; ckpt_restore_id = vecs[v].rs_id;
            rd_addr = vecs[v].ra;
            tick();
            for (int i = 0; i < 4; i++) check("vec_rd_busy", v * 4 + i, 32'(rd_busy[i]), 32'(vecs[v].exp_busy[i]));
            check("vec_busy_count", v, 32'(busy_count), 32'(vecs[v].exp_cnt));
            $display("vec %0d rd_busy=%b busy_count=%0d", v, rd_busy, busy_count);
        end

        // Wakeup bypass: register 7 busy, clear it while reading it.
        set_en = 2'b01; set_addr[0] = 6'd7; rd_addr = '0; rd_addr[0] = 6'd7;
        tick();
        check("byp_pre_busy", 0, 32'(rd_busy[0]), 32'd1);
        clr_en = 2'b01; clr_addr[0] = 6'd7;
        set_en = 2'b01; set_addr[0] = 6'd8; rd_addr[1] = 6'd8;
        #1;
`ifdef QU_BUSY_TABLE_BYPASS_EN
        check("byp_same_cycle", 0, 32'(rd_busy[0]), 32'd0);
`else
        check("byp_same_cycle", 0, 32'(rd_busy[0]), 32'd1);
`endif
        check("set_not_bypassed", 0, 32'(rd_busy[1]), 32'd0);
        tick();
        check("byp_next_cycle", 0, 32'(rd_busy[0]), 32'd0);
        check("set_visible", 0, 32'(rd_busy[1]), 32'd1);
        check("byp_count", 0, 32'(busy_count), 32'd1);
        $display("bypass seq rd_busy=%b busy_count=%0d", rd_busy, busy_count);

        // Reset in the middle of set/save/restore activity.
        set_en = 2'b11; set_addr[0] = 6'd11; set_addr[1] = 6'd12;
        tick();
        check("pre_rst_count", 0, 32'(busy_count), 32'd3);
        ckpt_save_en = 1'b1; ckpt_save_id = 2'd0;
        tick();
        rst = 1'b1; set_en = 2'b01; set_addr[0] = 6'd13;
        ckpt_restore_en = 1'b1; ckpt_restore_id = 2'd0;
        ckpt_save_en = 1'b1; ckpt_save_id = 2'd2;
        rd_addr[0] = 6'd11; rd_addr[1] = 6'd12; rd_addr[2] = 6'd13; rd_addr[3] = 6'd8;
        tick();
        check("rst_rd_busy", 0, 32'(rd_busy), 32'd0);
        check("rst_count", 0, 32'(busy_count), 32'd0);
        $display("reset seq rd_busy=%b busy_count=%0d", rd_busy, busy_count);
        rd_addr[0] = 6'd2; rd_addr[1] = 6'd5;
        for (int s = 0; s < 4; s++) begin
            ckpt_restore_en = 1'b1; ckpt_restore_id = 2'(s);
            tick();
            check("post_rst_restore_busy", s, 32'(rd_busy), 32'd0);
            check("post_rst_restore_count", s, 32'(busy_count), 32'd0);
            $display("restore slot %0d after reset rd_busy=%b busy_count=%0d", s, rd_busy, busy_count);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multiport_busy_table.md
MULTIPORT_BUSY_TABLE -- requirements
Module: multiport_busy_table

Interface
REQ-001 Parameter PHY_RF_DEPTH, default 64: number of physical registers; address width AW = $clog2(PHY_RF_DEPTH).
REQ-002 Parameter NUM_RD, default 4: number of read ports.
REQ-003 Parameter NUM_SET, default 2: number of allocate (set-busy) ports.
REQ-004 Parameter NUM_CLR, default 2: number of writeback (clear-busy) ports.
REQ-005 Parameter NUM_CKPT, default 4: number of branch checkpoints; CW = $clog2(NUM_CKPT).
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 rd_addr  in  NUM_RD x AW  read addresses.
REQ-009 rd_busy  out  NUM_RD  busy bit of each addressed register.
REQ-010 set_en / set_addr  in  NUM_SET x 1 / NUM_SET x AW  mark register busy.
REQ-011 clr_en / clr_addr  in  NUM_CLR x 1 / NUM_CLR x AW  mark register not busy.
REQ-012 ckpt_save_en / ckpt_save_id  in  1 / CW  snapshot the table into one slot.
REQ-013 ckpt_restore_en / ckpt_restore_id  in  1 / CW  reload the table from one slot.
REQ-014 busy_count  out  AW+1  registered number of busy entries.

Function
REQ-015 Read ports are combinational from the current table; there is no read latency.
REQ-016 Set and clear operations take effect at the next rising edge; all ports are independent, and duplicate addresses across ports are legal.
REQ-017 Address 0 is never busy: rd_busy reads 0 for it, and set/clear operations to it are ignored.
REQ-018 Set and clear to the same address in the same cycle: set wins.
REQ-019 Next-state ordering: restore (if enabled) replaces the table with the slot contents; then clears apply; then sets apply, but only when no restore occurs.
REQ-020 A restore suppresses all sets in that cycle, because the flushed allocations are discarded.
REQ-021 Every valid clear also clears that bit in all NUM_CKPT slots in the same edge, so later restores never resurrect completed registers.
REQ-022 Save writes the table's next-state value, including this cycle's sets and clears, into slot ckpt_save_id.
REQ-023 Save and restore in the same cycle: the restore is performed and the save is ignored.
REQ-024 A save targeting the slot being restored is likewise ignored.
REQ-025 busy_count equals the popcount of the table after the same edge and is registered, never combinational; its range is 0..PHY_RF_DEPTH-1.
REQ-026 An out-of-range ckpt id, when NUM_CKPT is not a power of two, is ignored without any state change.

Reset
REQ-027 While rst=1 at an edge, the table, all checkpoint slots and busy_count become 0; all other inputs are ignored in that cycle.
REQ-028 Reset asserted mid-operation, including together with save/restore/set, yields the pure reset state.
REQ-029 Directly after reset, every rd_busy reads 0.

Configuration
REQ-030 Macro QU_BUSY_TABLE_BYPASS_EN defined: rd_busy is forced 0 combinationally for any address matched by a valid clear port in the same cycle (wakeup bypass).
REQ-031 Macro QU_BUSY_TABLE_BYPASS_EN undefined: rd_busy reflects only the registered table, so a clear becomes visible one cycle later.
REQ-032 Sets and restores are never bypassed in either configuration.

Structure
REQ-033 Package qu_common holds PHY_RF_DEPTH, NUM_CKPT and the typedefs phy_addr_t (AW bits) and ckpt_id_t (CW bits).
REQ-034 One sub-module, busy_popcount (PHY_RF_DEPTH-bit population count, combinational), feeds the busy_count register.
REQ-035 The checkpoint array is registers, not RAM, because every slot is cleared in parallel.

Verification
REQ-036 Reset, then set 1 and 2 on both ports; read 1,2,3 -> 1,1,0 next cycle; busy_count = 2.
REQ-037 Set 5 on port 0 and clear 5 on port 1 in the same cycle -> rd_busy(5) = 1; set 0 -> rd_busy(0) = 0 and busy_count unchanged.
REQ-038 With bypass enabled, register 7 busy and clr 7 while reading 7 -> same-cycle rd_busy = 0; without bypass -> 1 this cycle, 0 next cycle.
REQ-039 Set 3; save slot 1 together with set 4; set 9; clear 3; restore slot 1 -> 3=0, 4=1, 9=0; busy_count = 1.
REQ-040 Restore slot 2 in the same cycle as set 10, clear 4 and save slot 2 -> set ignored, 4 cleared, slot 2 unchanged.
REQ-041 Set 11 and 12, then rst=1 in the same cycle as set 13 and restore -> all reads 0 and busy_count = 0; a later restore of any slot yields an all-zero table.
